// File: rtl/ternary_to_binary_4digit.sv
// Serial ternary-to-binary converter for the 5-trit adder result (Cout, S3..S0).
// Horner evaluation, MSD first, one trit per clock, with valid/ready handshakes on both sides.
module ternary_to_binary_4digit (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       Cout,
   input  logic [1:0] S3,
   input  logic [1:0] S2,
   input  logic [1:0] S1,
   input  logic [1:0] S0,
   output logic [7:0] bin,
   output logic       err,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] dbg_state
);

   // Handshake: a word moves on any rising edge where valid and ready are both high;
   // in_ready and out_valid are registered and depend only on state, never on inputs.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] digits_q, digits_d;
   logic [7:0] acc_q, acc_d;
   logic [1:0] cnt_q, cnt_d;
   logic       err_int_q, err_int_d;
   logic [7:0] bin_q, bin_d;
   logic       err_q, err_d;
   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;

   logic [1:0] msd;
   logic       msd_bad;
   logic [1:0] msd_val;
   logic [7:0] step;

   always_comb begin
      msd     = digits_q[7:6];
      msd_bad = (msd == 2'b11);
      msd_val = msd_bad ? 2'b00 : msd;
      // acc never exceeds 53 before a step, so acc*3+2 fits in 8 bits
      step    = {acc_q[6:0], 1'b0} + acc_q + {6'b0, msd_val};

      state_d     = state_q;
      digits_d    = digits_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      err_int_d   = err_int_q;
      bin_d       = bin_q;
      err_d       = err_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               digits_d   = {S3, S2, S1, S0};
               acc_d      = {7'b0, Cout};
               err_int_d  = 1'b0;
               cnt_d      = 2'd3;
               state_d    = CONV;
               in_ready_d = 1'b0;
            end else begin
               in_ready_d = 1'b1;
            end
         end
         CONV: begin
            acc_d     = step;
            digits_d  = {digits_q[5:0], 2'b00};
            err_int_d = err_int_q | msd_bad;
            cnt_d     = cnt_q - 2'd1;
            if (cnt_q == 2'd0) begin
               bin_d       = step;
               err_d       = err_int_q | msd_bad;
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         digits_q    <= 8'h00;
         acc_q       <= 8'h00;
         cnt_q       <= 2'd0;
         err_int_q   <= 1'b0;
         bin_q       <= 8'h00;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         digits_q    <= digits_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         err_int_q   <= err_int_d;
         bin_q       <= bin_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign bin       = bin_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ternary_to_binary_4digit.sv
// Self-checking bench for ternary_to_binary_4digit: scoreboard of {err,bin} plus
// latency, pulse-width, backpressure and reset checks.
module tb_ternary_to_binary_4digit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       cout;
   logic [1:0] s3, s2, s1, s0;
   logic [7:0] bin;
   logic       err;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [8:0] exp_q[$];
   int         acc_cyc_q[$];
   logic       ov_prev  = 1'b0;
   logic       hs_prev  = 1'b0;

   ternary_to_binary_4digit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Cout      (cout),
      .S3        (s3),
      .S2        (s2),
      .S1        (s1),
      .S0        (s0),
      .bin       (bin),
      .err       (err),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int tval(input logic [1:0] t);
      return (t == 2'b11) ? 0 : int'(t);
   endfunction

   function automatic logic [8:0] model(input logic c, input logic [1:0] t3, t2, t1, t0);
      int   v;
      logic e;
      v = (c ? 81 : 0) + 27 * tval(t3) + 9 * tval(t2) + 3 * tval(t1) + tval(t0);
      e = (t3 == 2'b11) || (t2 == 2'b11) || (t1 == 2'b11) || (t0 == 2'b11);
      return {e, v[7:0]};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic send(input logic c, input logic [1:0] t3, t2, t1, t0, output int acc_cyc);
      logic done;
      done    = 1'b0;
      acc_cyc = -1;
      @(negedge clk);
      cout = c; s3 = t3; s2 = t2; s1 = t1; s0 = t0;
      in_valid = 1'b1;
      for (int i = 0; i < 40 && !done; i++) begin
         if (in_ready) begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            exp_q.push_back(model(c, t3, t2, t1, t0));
            acc_cyc_q.push_back(cyc);
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      if (!done) check_eq("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      check_eq("drain_empty", exp_q.size(), 0);
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         ov_prev = 1'b0;
         hs_prev = 1'b0;
      end else begin
         if (hs_prev) begin
            check_eq("ov_drop", out_valid, 1'b0);
            check_eq("in_ready_after_done", in_ready, 1'b1);
         end
         if (out_valid && !ov_prev) begin
            if (acc_cyc_q.size() != 0) check_eq("latency", cyc - acc_cyc_q[0], 4);
            else check_eq("unexpected_valid", 32'd1, 32'd0);
         end
         hs_prev = out_valid && out_ready;
         if (out_valid && out_ready) begin
            if (exp_q.size() != 0) begin
               check_eq("result", {err, bin}, exp_q.pop_front());
               void'(acc_cyc_q.pop_front());
            end else begin
               check_eq("unexpected_out", 32'd1, 32'd0);
            end
         end
         ov_prev = out_valid;
      end
   end

   // ---------------- stimulus ----------------
   initial begin : main
      int a0, a1;
      logic [7:0] bin_hold;
      logic       err_hold;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      cout = 1'b0; s3 = 2'b00; s2 = 2'b00; s1 = 2'b00; s0 = 2'b00;
      repeat (3) @(negedge clk);
      check_eq("rst_bin", bin, 8'h00);
      check_eq("rst_err", err, 1'b0);
      check_eq("rst_out_valid", out_valid, 1'b0);
      check_eq("rst_in_ready", in_ready, 1'b0);
      check_eq("rst_state", dbg_state, 2'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("in_ready_after_rst", in_ready, 1'b1);

      // zero, maximum, mixed with back-to-back throughput
      send(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, a0);
      drain();
      send(1'b1, 2'b10, 2'b10, 2'b10, 2'b10, a0);
      drain();
      send(1'b0, 2'b01, 2'b00, 2'b10, 2'b01, a0);
      send(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, a1);
      check_eq("throughput", a1 - a0, 6);
      drain();

      // invalid trit, then a clean conversion clears err
      send(1'b0, 2'b00, 2'b00, 2'b11, 2'b01, a0);
      send(1'b0, 2'b01, 2'b10, 2'b00, 2'b01, a0);
      drain();

      // backpressure with in_valid pulses that must be ignored
      out_ready = 1'b0;
      send(1'b1, 2'b01, 2'b01, 2'b01, 2'b01, a0);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      check_eq("bp_valid_seen", out_valid, 1'b1);
      bin_hold = bin;
      err_hold = err;
      for (int i = 0; i < 5; i++) begin
         cout = 1'b0; s3 = 2'b10; s2 = 2'b00; s1 = 2'b01; s0 = 2'b10;
         in_valid = (i % 2 == 0);
         @(negedge clk);
         check_eq("bp_out_valid", out_valid, 1'b1);
         check_eq("bp_bin", bin, bin_hold);
         check_eq("bp_err", err, err_hold);
         check_eq("bp_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      check_eq("bp_state_idle", dbg_state, 2'd0);

      // reset in the middle of a conversion
      send(1'b1, 2'b10, 2'b01, 2'b10, 2'b01, a0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      acc_cyc_q.delete();
      @(negedge clk);
      check_eq("midrst_out_valid", out_valid, 1'b0);
      check_eq("midrst_bin", bin, 8'h00);
      check_eq("midrst_err", err, 1'b0);
      check_eq("midrst_in_ready", in_ready, 1'b0);
      rst = 1'b0;
      send(1'b0, 2'b01, 2'b01, 2'b01, 2'b01, a0);
      drain();

      // reset and in_valid together: nothing is captured
      rst = 1'b1;
      cout = 1'b1; s3 = 2'b10; s2 = 2'b10; s1 = 2'b10; s0 = 2'b10;
      in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      check_eq("rst_wins_state", dbg_state, 2'd0);
      check_eq("rst_wins_out_valid", out_valid, 1'b0);

      // random vectors, including invalid trits, with random consumer stalls
      for (int i = 0; i < 12; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), a0);
         for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 2) != 0);
         end
         out_ready = 1'b1;
         drain();
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
